icache_responder: RTL
=====================

Name: icache_responder

Overview:
- Direct-mapped instruction cache that sits on the cache side of the datapath/cache instruction interface.
- Answers the pipeline's instruction fetch requests (imemREN/imemaddr) with ihit/imemload.
- On a miss, issues single-word reads to the memory controller (iREN/iaddr, completed by iwait/iload) and fills the frame.
- The datapath's PC only advances on ihit, so this block sets fetch throughput.

Parameters:
- SETS, 16, number of one-word frames; power of two, at least 2.
- IDX_W, 4, index width, equal to log2(SETS).
- CNT_W, 32, width of the hit and miss performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  instruction read request from the datapath.
- imemaddr  in  32  fetch address; bits [1:0] ignored.
- ihit  out  1  imemload valid for the current imemaddr this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  read request to the memory controller.
- iaddr  out  32  word address of the outstanding miss; bits [1:0] are always 0.
- iwait  in  1  memory busy; iwait=0 while iREN=1 means iload is valid this cycle.
- iload  in  32  word returned by memory.
- hit_count  out  CNT_W  number of cycles with ihit=1.
- miss_count  out  CNT_W  number of misses started.

Behaviour:
- Address split:
  - index = imemaddr[IDX_W+1:2].
  - tag = imemaddr[31:IDX_W+2].
- Frame storage: valid bit, tag and 32-bit data per frame.
- Reset (asynchronous, nRST=0):
  - All valid bits cleared; state goes to IDLE; miss_addr=0; both counters 0.
  - Outputs while in reset: ihit=0, iREN=0, iaddr=0, imemload=0.
- States: IDLE and FETCH.
- IDLE:
  - lookup_hit = imemREN & valid[index] & (stored tag == tag).
  - ihit = lookup_hit, combinational, in the same cycle as the request.
  - imemload = frame data when lookup_hit, otherwise 0.
  - iREN=0; iaddr=0.
  - imemREN=1 with a miss: latch miss_addr = {imemaddr[31:2],2'b00}; miss_count+1; go to FETCH on the next edge.
  - imemREN=0: ihit=0; no state change.
- FETCH:
  - ihit=0; imemload=0; iREN=1; iaddr=miss_addr, held stable for the whole fetch regardless of imemaddr.
  - iwait=1: stay in FETCH.
  - iwait=0: on that edge write frame[miss_addr index] with valid=1, tag from miss_addr, data=iload; return to IDLE.
  - No bypass of iload to imemload: first-miss latency is (memory wait cycles + 1) cycles to ihit.
  - Earliest ihit is the first IDLE cycle after the fill, via a normal lookup.
- imemaddr changes during FETCH (branch/jump redirect):
  - The outstanding fetch still completes and still fills the frame for miss_addr.
  - The new address is looked up in the IDLE cycle after the fill; it may hit, or start a new miss.
- Conflicting addresses: same index, different tag replaces the frame (direct-mapped overwrite). The old line then misses.
- Back-to-back: a miss can begin in the same IDLE cycle that follows a fill; there are no idle bubbles beyond one.
- Counters:
  - hit_count increments on every cycle with ihit=1 (a stalled pipeline re-hitting counts each cycle).
  - Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-FETCH: the fetch is abandoned and iREN drops immediately (asynchronously). The partial fill is never written.
- The block never writes memory and has no dirty state; instruction memory is read-only from this side.

Test Plan:
- Cold miss: nRST release; imemREN=1, imemaddr=0x00000000, memory holds 0x3C010001 with iwait=1 for 3 cycles.
  - Required: iREN=1, iaddr=0 for 4 cycles.
  - Fill on the cycle with iwait=0; next cycle ihit=1, imemload=0x3C010001; miss_count=1.
- Repeat hit: same address held for 5 more cycles -> ihit=1 every cycle, iREN=0, hit_count=5.
- Conflict eviction: fill 0x00000004, then request 0x00000044 (same index 1).
  - 0x44 misses with iaddr=0x44; after the fill, 0x04 misses again; miss_count increments each time.
- Redirect mid-miss: miss on 0x00000010; during the wait cycles change imemaddr to 0x00000020.
  - Required: iaddr stays 0x10 until iwait=0; frame 4 is filled; the next cycle starts a miss with iaddr=0x20.
- Reset mid-fetch: assert nRST=0 while in FETCH with iwait=1.
  - Required: iREN=0 asynchronously; after release, 0x10 misses again (valid bits cleared); counters 0.
- Ignore low bits and idle request: with 0x08 cached, request 0x0000000B -> ihit=1 with the 0x08 data; imemREN=0 -> ihit=0, iREN=0.

Source files
------------

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped one-word-per-frame instruction cache with single-word miss fills.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [31:0]      miss_addr_q, miss_addr_d;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0]      data_q [SETS];
  logic [CNT_W-1:0] hit_count_q, miss_count_q;
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag;
  logic             lookup_hit, miss_start, fill, addr_lo_unused;
  assign addr_lo_unused = ^imemaddr[1:0];
  assign idx        = imemaddr[IDX_W+1:2];
  assign tag        = imemaddr[31:IDX_W+2];
  assign fill_idx   = miss_addr_q[IDX_W+1:2];
  assign lookup_hit = (state_q == IDLE) && imemREN && valid_q[idx] && (tag_q[idx] == tag);
  assign miss_start = (state_q == IDLE) && imemREN && !lookup_hit;
  assign fill       = (state_q == FETCH) && !iwait;
  assign ihit       = lookup_hit;
  assign imemload   = lookup_hit ? data_q[idx] : 32'h0;
  assign iREN       = (state_q == FETCH);
  assign iaddr      = iREN ? miss_addr_q : 32'h0;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  always_comb begin
    state_d     = miss_start ? FETCH : (fill ? IDLE : state_q);
    miss_addr_d = miss_start ? {imemaddr[31:2], 2'b00} : miss_addr_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
      if (lookup_hit) hit_count_q <= hit_count_q + CNT_W'(1);
      if (miss_start) miss_count_q <= miss_count_q + CNT_W'(1);
    end
  end
  // Frame payload needs no reset; validity alone gates its use.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= miss_addr_q[31:IDX_W+2];
      data_q[fill_idx] <= iload;
    end
  end
endmodule
